// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a one-cycle data RAM.
// Optional request counters enabled with `define LSU_STATS_EN.
module load_store_unit #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       ram_address,
  output logic [31:0]       ram_data_write,
  output logic              ram_write_en,
  output logic              ram_read_en,
  input  logic [31:0]       ram_data_in
`ifdef LSU_STATS_EN
  ,
  output logic [15:0]       stat_loads,
  output logic [15:0]       stat_stores,
  output logic [15:0]       stat_faults
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_DATA,
    S_WR,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_write;
  logic [1:0]          r_size;
  logic                r_signed;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_fault;

  logic                w_accept;
  logic                w_fault;
  logic                w_rd;
  logic                w_wr;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;
  logic [31:0]         w_merge;
  logic [ADDR_W-1:0]   w_waddr;

  assign req_ready = (r_state == S_IDLE) & rst_n;
  assign w_accept  = req_valid & req_ready;

  assign w_fault = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (|req_addr[1:0]))
                 | (req_addr >= ADDR_W'(MEM_BYTES));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: faults skip the RAM, word stores skip the read
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_fault)
            w_next = S_RESP;
          else if (req_write && req_size == 2'b10)
            w_next = S_WR;
          else
            w_next = S_RD;
        end
      end
      S_RD:      w_next = S_RD_DATA;
      S_RD_DATA: w_next = r_write ? S_WR : S_RESP;
      S_WR:      w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Big-endian lane extraction and sign/zero extension
  always_comb begin
    w_byte = 8'h00;
    unique case (r_addr[1:0])
      2'd0: w_byte = ram_data_in[31:24];
      2'd1: w_byte = ram_data_in[23:16];
      2'd2: w_byte = ram_data_in[15:8];
      2'd3: w_byte = ram_data_in[7:0];
      default: w_byte = 8'h00;
    endcase
    w_half = r_addr[1] ? ram_data_in[15:0] : ram_data_in[31:16];
    w_load = ram_data_in;
    if (r_size == 2'b00)
      w_load = r_signed ? {{24{w_byte[7]}}, w_byte}
                        : {24'h0, w_byte};
    else if (r_size == 2'b01)
      w_load = r_signed ? {{16{w_half[15]}}, w_half}
                        : {16'h0, w_half};
  end

  // Merge the store lane into the word read back from RAM
  always_comb begin
    w_merge = ram_data_in;
    if (r_size == 2'b00) begin
      unique case (r_addr[1:0])
        2'd0: w_merge[31:24] = r_wdata[7:0];
        2'd1: w_merge[23:16] = r_wdata[7:0];
        2'd2: w_merge[15:8]  = r_wdata[7:0];
        2'd3: w_merge[7:0]   = r_wdata[7:0];
        default: w_merge = ram_data_in;
      endcase
    end else if (r_size == 2'b01) begin
      if (r_addr[1]) w_merge[15:0]  = r_wdata[15:0];
      else           w_merge[31:16] = r_wdata[15:0];
    end
  end

  // Request capture, load result and merged store word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_fault  <= 1'b0;
    end else if (w_accept) begin
      r_write  <= req_write;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_rdata  <= 32'h0;
      r_fault  <= w_fault;
    end else if (r_state == S_RD_DATA) begin
      if (r_write) r_wdata <= w_merge;
      else         r_rdata <= w_load;
    end
  end

  assign w_rd    = (r_state == S_RD);
  assign w_wr    = (r_state == S_WR);
  assign w_waddr = {r_addr[ADDR_W-1:2], 2'b00};

  // Strobes drop with rst_n so a reset during WR never commits
  assign ram_read_en    = w_rd & rst_n;
  assign ram_write_en   = w_wr & rst_n;
  assign ram_address    = (w_rd | w_wr) ? 32'(w_waddr) : 32'h0;
  assign ram_data_write = w_wr ? r_wdata : 32'h0;

  assign resp_valid = (r_state == S_RESP);
  assign resp_err   = resp_valid & r_fault;
  assign resp_rdata = resp_valid ? r_rdata : 32'h0;

`ifdef LSU_STATS_EN
  logic [15:0] r_loads;
  logic [15:0] r_stores;
  logic [15:0] r_faults;

  // Saturating completion counters, bumped in RESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_loads  <= 16'h0;
      r_stores <= 16'h0;
      r_faults <= 16'h0;
    end else if (r_state == S_RESP) begin
      if (r_fault) begin
        if (r_faults != 16'hFFFF) r_faults <= r_faults + 16'h1;
      end else if (r_write) begin
        if (r_stores != 16'hFFFF) r_stores <= r_stores + 16'h1;
      end else begin
        if (r_loads != 16'hFFFF) r_loads <= r_loads + 16'h1;
      end
    end
  end

  assign stat_loads  = r_loads;
  assign stat_stores = r_stores;
  assign stat_faults = r_faults;
`endif

endmodule
